// File: rtl/iterative_divider.sv
// Multi-cycle RV32M divide/remainder unit (DIV/DIVU/REM/REMU), radix-2 restoring, one bit per cycle.
// Optional DIVIDER_FASTPATH_EN: divide-by-zero and signed overflow finish in one cycle.
module iterative_divider #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [1:0]            divOp,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic                  respValid,
    input  logic                  respReady,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONE = '1;

    state_t                state_q, state_d;
    logic [1:0]            op_q;
    logic                  neg1_q, neg2_q, zero_q, ovf_q;
    logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q, op1_q, result_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  accept, fast, in_signed, in_zero, in_ovf, last;
    logic [DATA_WIDTH-1:0] abs1, abs2;
    logic [DATA_WIDTH:0]   rem_sh, trial;
    logic [DATA_WIDTH-1:0] rem_next, quo_next, q_fix, r_fix, final_res;
    logic                  q_signed;

    assign reqReady  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign respValid = (state_q == DONE);
    assign result    = result_q;

    assign accept    = reqValid && reqReady && !flush;
    assign in_signed = !divOp[0];
    assign in_zero   = (op2 == '0);
    assign in_ovf    = in_signed && (op1 == MIN_NEG) && (op2 == ALL_ONE);
    assign abs1      = (in_signed && op1[DATA_WIDTH-1]) ? -op1 : op1;
    assign abs2      = (in_signed && op2[DATA_WIDTH-1]) ? -op2 : op2;

    // Partial remainder is one bit wider after the shift so large divisors restore correctly.
    assign rem_sh   = {rem_q, quo_q[DATA_WIDTH-1]};
    assign trial    = rem_sh - {1'b0, dvs_q};
    assign rem_next = trial[DATA_WIDTH] ? rem_sh[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
    assign quo_next = {quo_q[DATA_WIDTH-2:0], !trial[DATA_WIDTH]};
    assign last     = (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));

    always_comb begin
        q_signed  = !op_q[0];
        q_fix     = (q_signed && (neg1_q != neg2_q)) ? -quo_next : quo_next;
        r_fix     = (q_signed && neg1_q) ? -rem_next : rem_next;
        if (zero_q) begin
            q_fix = ALL_ONE;
            r_fix = op1_q;
        end else if (ovf_q) begin
            q_fix = MIN_NEG;
            r_fix = '0;
        end
        final_res = op_q[1] ? r_fix : q_fix;
    end

`ifdef DIVIDER_FASTPATH_EN
    logic [DATA_WIDTH-1:0] fast_res;
    assign fast = accept && (in_zero || in_ovf);
    always_comb begin
        if (in_zero) fast_res = divOp[1] ? op1 : ALL_ONE;
        else         fast_res = divOp[1] ? '0 : MIN_NEG;
    end
`else
    assign fast = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = fast ? DONE : CALC;
            CALC: begin
                if (flush)     state_d = IDLE;
                else if (last) state_d = DONE;
            end
            DONE: if (flush || respReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            op1_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q   <= divOp;
                    neg1_q <= in_signed && op1[DATA_WIDTH-1];
                    neg2_q <= in_signed && op2[DATA_WIDTH-1];
                    zero_q <= in_zero;
                    ovf_q  <= in_ovf;
                    rem_q  <= '0;
                    quo_q  <= abs1;
                    dvs_q  <= abs2;
                    op1_q  <= op1;
                    cnt_q  <= '0;
`ifdef DIVIDER_FASTPATH_EN
                    if (fast) result_q <= fast_res;
`endif
                end
                CALC: if (!flush) begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) result_q <= final_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed ops, special cases, backpressure, flush, reset.
module tb_iterative_divider;
    logic        clk = 0, rst = 1, flush = 0, reqValid = 0, respReady = 0;
    logic [1:0]  divOp = 0;
    logic [31:0] op1 = 0, op2 = 0;
    logic        reqReady, respValid, busy;
    logic [31:0] result;

    int total = 0, bad = 0;
    logic [31:0] exp_q[$];

`ifdef DIVIDER_FASTPATH_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    iterative_divider dut (
        .clk(clk), .rst(rst), .flush(flush), .reqValid(reqValid), .reqReady(reqReady),
        .divOp(divOp), .op1(op1), .op2(op2), .respValid(respValid), .respReady(respReady),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue one op, measure latency, hold the response `hold` cycles, then release it.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv, input int lat,
                          input int hold);
        int n;
        logic [31:0] e;
        @(negedge clk);
        check({tag, "_req_ready"}, 32'(reqReady), 32'd1);
        divOp = op; op1 = a; op2 = b; reqValid = 1;
        exp_q.push_back(expv);
        @(posedge clk); #1;
        reqValid = 0;
        n = 1;
        while (!respValid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        e = exp_q.pop_front();
        check({tag, "_result"}, result, e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_result"}, result, e);
            check({tag, "_hold_valid"}, 32'(respValid), 32'd1);
            check({tag, "_hold_reqready"}, 32'(reqReady), 32'd0);
        end
        @(negedge clk);
        respReady = 1;
        @(posedge clk); #1;
        respReady = 0;
        check({tag, "_release_valid"}, 32'(respValid), 32'd0);
        check({tag, "_release_reqready"}, 32'(reqReady), 32'd1);
    endtask

    task automatic expect_silence(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (respValid) seen++;
        end
        check({tag, "_no_resp"}, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        #2;
        check("reset_valid", 32'(respValid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_reqready", 32'(reqReady), 32'd1);
        @(negedge clk); rst = 0;

        run_op("divu_bp", 2'b01, 32'd100, 32'd7, 32'd14, 33, 5);
        run_op("remu", 2'b11, 32'd100, 32'd7, 32'd2, 33, 0);
        run_op("div_neg", 2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0);
        run_op("rem_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0);
        run_op("div_negdvs", 2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 0);
        run_op("rem_negdvs", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 33, 0);
        run_op("div_by0", 2'b00, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, SPECIAL_LAT, 0);
        run_op("rem_by0", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, SPECIAL_LAT, 0);
        run_op("divu_by0", 2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, SPECIAL_LAT, 0);
        run_op("remu_by0", 2'b11, 32'd5, 32'd0, 32'd5, SPECIAL_LAT, 0);
        run_op("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_LAT, 0);
        run_op("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, SPECIAL_LAT, 0);
        run_op("divu_minneg", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33, 0);
        run_op("divu_bigdvs", 2'b01, 32'hFFFFFFFF, 32'h80000001, 32'd1, 33, 0);
        run_op("remu_bigdvs", 2'b11, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33, 0);
        for (int k = 0; k < 4; k++) begin
            ra = $urandom;
            rb = $urandom_range(1, 32'h0000FFFF);
            run_op("divu_rand", 2'b01, ra, rb, ra / rb, 33, 0);
            run_op("remu_rand", 2'b11, ra, rb, ra % rb, 33, 0);
        end

        // flush together with a request in IDLE: nothing accepted
        @(negedge clk);
        flush = 1; reqValid = 1; divOp = 2'b01; op1 = 32'd9; op2 = 32'd3;
        @(posedge clk); #1;
        flush = 0; reqValid = 0;
        check("idle_flush_busy", 32'(busy), 32'd0);

        // flush during CALC
        @(negedge clk);
        divOp = 2'b01; op1 = 32'd100; op2 = 32'd7; reqValid = 1;
        @(posedge clk); #1;
        reqValid = 0;
        repeat (10) @(posedge clk);
        @(negedge clk); flush = 1;
        @(posedge clk); #1;
        flush = 0;
        check("flush_valid", 32'(respValid), 32'd0);
        check("flush_reqready", 32'(reqReady), 32'd1);
        expect_silence("flush", 40);

        // async reset during CALC
        @(negedge clk);
        divOp = 2'b01; op1 = 32'd100; op2 = 32'd7; reqValid = 1;
        @(posedge clk); #1;
        reqValid = 0;
        repeat (20) @(posedge clk);
        #2 rst = 1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_valid", 32'(respValid), 32'd0);
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_reqready", 32'(reqReady), 32'd1);
        @(negedge clk); rst = 0;
        expect_silence("rst_mid", 40);

        run_op("post_rst", 2'b01, 32'd100, 32'd7, 32'd14, 33, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
